// File: rtl/sc_pkg.sv
// sc_pkg: shared constants for the stochastic-computing blocks.
//   SC_WIDTH      - binary width of counts and results (also used by SNG/LFSR blocks)
//   SC_STREAM_LEN - samples per window; one full period of the 8-bit LFSR
//   ST_*          - decoder FSM state encodings (plain constants for legacy tools)
package sc_pkg;

    localparam int SC_WIDTH      = 8;
    localparam int SC_STREAM_LEN = 255;

    typedef logic [1:0] sc_state_t;

    localparam sc_state_t ST_IDLE  = 2'd0;
    localparam sc_state_t ST_COUNT = 2'd1;
    localparam sc_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if: stochastic input stream plus the result handshake.
//   in_x, in_en           - stochastic bit and its sample-valid qualifier
//   out_value, out_valid  - result and its valid flag (held until accepted)
//   out_ready             - consumer accepts the result
// Modports: master = decoder side, slave = stream source / result consumer.
interface sc_stream_decoder_if #(
    parameter int WIDTH = sc_pkg::SC_WIDTH
);
    logic             in_x;
    logic             in_en;
    logic [WIDTH-1:0] out_value;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  in_x,
        input  in_en,
        input  out_ready,
        output out_value,
        output out_valid
    );

    modport slave (
        output in_x,
        output in_en,
        output out_ready,
        input  out_value,
        input  out_valid
    );
endinterface

// File: rtl/sc_window_counter.sv
// sc_window_counter: counts valid samples in one window.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart the window at zero (wins over en)
//   en         - one valid sample this cycle
//   last       - the sample taken this cycle completes the window
module sc_window_counter #(
    parameter int WIDTH      = sc_pkg::SC_WIDTH,
    parameter int STREAM_LEN = sc_pkg::SC_STREAM_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic last
);
    logic [WIDTH-1:0] samp_cnt_q;
    logic [WIDTH-1:0] samp_cnt_d;

    // Terminal count is flagged on the sample that would bring the count
    // to STREAM_LEN, so the caller can fold that final bit in the same cycle.
    assign last = en && (samp_cnt_q == WIDTH'(STREAM_LEN - 1));

    always_comb begin
        samp_cnt_d = samp_cnt_q;
        if (clear) begin
            samp_cnt_d = '0;
        end else if (en) begin
            samp_cnt_d = samp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_q <= '0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
        end
    end
endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: stochastic-to-binary converter. Counts the 1s over a
// window of STREAM_LEN valid samples and hands the count out on a
// valid/ready handshake.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - begin a conversion (IDLE, or DONE together with the handshake)
//   abort      - drop the conversion in progress (only acts in COUNT)
//   busy       - high while counting
//   bus        - stream input and result handshake (master modport)
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIDTH      = SC_WIDTH,
    parameter int STREAM_LEN = SC_STREAM_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    sc_stream_decoder_if.master  bus
);
    sc_state_t        state_q,     state_d;
    logic [WIDTH-1:0] ones_cnt_q,  ones_cnt_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             out_valid_q, out_valid_d;

    logic win_clear;
    logic win_en;
    logic win_last;

    sc_window_counter #(
        .WIDTH      (WIDTH),
        .STREAM_LEN (STREAM_LEN)
    ) u_window (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (win_clear),
        .en    (win_en),
        .last  (win_last)
    );

    always_comb begin
        state_d     = state_q;
        ones_cnt_d  = ones_cnt_q;
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;
        win_clear   = 1'b0;
        win_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_COUNT;
                    ones_cnt_d = '0;
                    win_clear  = 1'b1;
                end
            end
            ST_COUNT: begin
                // abort beats everything, including the final sample
                if (abort) begin
                    state_d    = ST_IDLE;
                    ones_cnt_d = '0;
                    win_clear  = 1'b1;
                end else if (bus.in_en) begin
                    win_en = 1'b1;
                    if (win_last) begin
                        out_value_d = ones_cnt_q + WIDTH'(bus.in_x);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                        ones_cnt_d  = '0;
                        win_clear   = 1'b1;
                    end else begin
                        ones_cnt_d = ones_cnt_q + WIDTH'(bus.in_x);
                    end
                end
            end
            ST_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        // back-to-back: the next window starts with no idle cycle
                        state_d    = ST_COUNT;
                        ones_cnt_d = '0;
                        win_clear  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ones_cnt_q  <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_cnt_q  <= ones_cnt_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy          = (state_q == ST_COUNT);
    assign bus.out_value = out_value_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sc_stream_decoder.sv
module tb_sc_stream_decoder;

    localparam int N = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;

    sc_stream_decoder_if bus ();

    sc_stream_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    // pat: 0 all ones, 1 alternating 1,0.., 2 all zeros, 3 LFSR SNG (seed 1, x<64)
    typedef struct {
        int pat;
        bit gaps;
        int exp_val;
        string name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_conv(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_on_start"}, int'(busy), 1);
    endtask

    // Drives n enabled samples; the bench counts the 1s it sends. With gaps,
    // every sample is preceded by an in_en=0 cycle carrying in_x=1.
    task automatic feed(input int pat, input bit gaps, input int n,
                        input bit abort_last, output int ones);
        logic [7:0] lfsr;
        bit b;
        lfsr = 8'h01;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                @(negedge clk);
                bus.in_en = 1'b0;
                bus.in_x  = 1'b1;
            end
            case (pat)
                0:       b = 1'b1;
                1:       b = (i % 2 == 0);
                2:       b = 1'b0;
                default: b = (lfsr < 8'd64);
            endcase
            @(negedge clk);
            if (i == n - 1) check("valid_before_last", int'(bus.out_valid), 0);
            bus.in_en = 1'b1;
            bus.in_x  = b;
            abort     = abort_last && (i == n - 1);
            ones += int'(b);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        @(negedge clk);
        bus.in_en = 1'b0;
        bus.in_x  = 1'b0;
        abort     = 1'b0;
    endtask

    // Called on the first negedge after the last sample was clocked in.
    task automatic collect(input string name, input int table_exp);
        int waited;
        int exp;
        waited = 0;
        check({name, "_latency"}, int'(bus.out_valid), 1);
        while (!bus.out_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got out_valid 0, expected 1 within 8 clk", name);
            void'(exp_q.pop_front());
        end else begin
            check({name, "_busy_done"}, int'(busy), 0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_scoreboard: got result %0d, expected none queued", name,
                         bus.out_value);
            end else begin
                exp = exp_q.pop_front();
                check({name, "_value"}, int'(bus.out_value), exp);
                check({name, "_table"}, int'(bus.out_value), table_exp);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check({name, "_valid_drop"}, int'(bus.out_valid), 0);
        end
        $display("txn %s done, out_value=%0d", name, bus.out_value);
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        bus.in_en = 1'b1;
        bus.in_x  = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        bus.in_en = 1'b0;
        bus.in_x  = 1'b0;
        check({name, "_no_valid"}, int'(seen), 0);
    endtask

    initial begin
        int ones;
        int held;

        vecs[0] = '{0, 1'b0, 255, "all_ones"};
        vecs[1] = '{1, 1'b0, 128, "alternating"};
        vecs[2] = '{2, 1'b0, 0,   "all_zeros"};
        vecs[3] = '{0, 1'b1, 255, "gaps"};
        vecs[4] = '{3, 1'b0, 63,  "sng_loopback"};

        bus.in_x      = 1'b0;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;

        #1;
        check("reset_busy",  int'(busy), 0);
        check("reset_valid", int'(bus.out_valid), 0);
        check("reset_value", int'(bus.out_value), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // table-driven windows
        for (int v = 0; v < 5; v++) begin
            start_conv(vecs[v].name);
            feed(vecs[v].pat, vecs[v].gaps, N, 1'b0, ones);
            exp_q.push_back(ones);
            collect(vecs[v].name, vecs[v].exp_val);
        end

        // backpressure, then ready+start back-to-back
        start_conv("bp");
        feed(0, 1'b0, N, 1'b0, ones);
        exp_q.push_back(ones);
        check("bp_latency", int'(bus.out_valid), 1);
        held = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_hold_value", int'(bus.out_value), held);
        end
        $display("txn bp held out_value=%0d for 5 clk", bus.out_value);
        bus.out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        start = 1'b0;
        check("b2b_busy", int'(busy), 1);
        check("b2b_valid", int'(bus.out_valid), 0);
        feed(1, 1'b0, N, 1'b0, ones);
        exp_q.push_back(ones);
        collect("b2b_alternating", 128);

        // abort at sample index 100
        start_conv("abort100");
        feed(0, 1'b0, 101, 1'b1, ones);
        check("abort100_busy", int'(busy), 0);
        watch_no_valid("abort100", 300);
        $display("txn abort100 done");

        // abort together with the final sample
        start_conv("abort_last");
        feed(0, 1'b0, N, 1'b1, ones);
        check("abort_last_valid", int'(bus.out_valid), 0);
        check("abort_last_busy", int'(busy), 0);
        watch_no_valid("abort_last", 10);
        $display("txn abort_last done");

        start_conv("after_abort");
        feed(0, 1'b0, N, 1'b0, ones);
        exp_q.push_back(ones);
        collect("after_abort", 255);

        // asynchronous reset mid-COUNT (out_value is still holding 255)
        start_conv("rst_mid");
        feed(0, 1'b0, 50, 1'b0, ones);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy",  int'(busy), 0);
        check("rst_mid_valid", int'(bus.out_valid), 0);
        check("rst_mid_value", int'(bus.out_value), 0);
        $display("txn rst_mid async reset applied");
        @(negedge clk);
        rst_n = 1'b1;
        start_conv("after_rst");
        feed(1, 1'b0, N, 1'b0, ones);
        exp_q.push_back(ones);
        collect("after_rst", 128);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before 2 ms");
        $fatal(1);
    end

endmodule
